// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
// regfile_wr_arbiter : round-robin arbiter sharing one registered register-file
//                      write port among 2**S requesters.
// Optional: ARB_LOCK_EN adds req_lock and an owner-lock FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wr_arbiter #(
    parameter int S = 2,
    parameter int R = 3,
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**S-1:0]       req,
    input  logic [(2**S)*R-1:0]   req_sel,
    input  logic [(2**S)*W-1:0]   req_data,
    input  logic                  rf_stall,
`ifdef ARB_LOCK_EN
    input  logic [2**S-1:0]       req_lock,
`endif
    output logic [2**S-1:0]       gnt,
    output logic                  wr_en,
    output logic [R-1:0]          wr_sel,
    output logic [W-1:0]          wr_data,
    output logic                  busy
);

    localparam int L = 2**S;

    logic [S-1:0] ptr_q, ptr_d;
    logic         wr_en_q, wr_en_d;
    logic [R-1:0] wr_sel_q, wr_sel_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         busy_q, busy_d;

    logic [S-1:0] scan_idx;
    logic [S-1:0] rr_win;
    logic         rr_any;
    logic [S-1:0] win;
    logic         cand;
    logic         xfer;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        rr_any   = 1'b0;
        rr_win   = '0;
        scan_idx = '0;
        for (int k = L - 1; k >= 0; k--) begin
            scan_idx = ptr_q + k[S-1:0];
            if (req[scan_idx]) begin
                rr_any = 1'b1;
                rr_win = scan_idx;
            end
        end
    end

`ifdef ARB_LOCK_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;
    state_e       state_q, state_d;
    logic [S-1:0] owner_q, owner_d;

    always_comb begin
        win  = rr_win;
        cand = rr_any;
        if (state_q == ST_LOCKED) begin
            win  = owner_q;
            cand = req[owner_q];
        end
    end
`else
    always_comb begin
        win  = rr_win;
        cand = rr_any;
    end
`endif

    always_comb begin
        gnt  = '0;
        xfer = cand & ~rf_stall & ~rst;
        if (xfer) begin
            gnt[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = xfer;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            wr_sel_d  = req_sel[win*R +: R];
            wr_data_d = req_data[win*W +: W];
            ptr_d     = win + 1'b1;
        end
`ifdef ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && req_lock[win]) begin
                    state_d = ST_LOCKED;
                    owner_d = win;
                end
            end
            ST_LOCKED: begin
                // Pointer is frozen while locked; released owner gets lowest priority.
                ptr_d = ptr_q;
                if (!req[owner_q] || (xfer && !req_lock[owner_q])) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`endif
        busy_d = wr_en_d | (|req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_LOCK_EN
            state_q   <= ST_IDLE;
            owner_q   <= '0;
`endif
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
`ifdef ARB_LOCK_EN
            state_q   <= state_d;
            owner_q   <= owner_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
// tb_regfile_wr_arbiter : scoreboard bench for regfile_wr_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

    localparam int S = 2;
    localparam int R = 3;
    localparam int W = 16;
    localparam int L = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [L-1:0]     req = '0;
    logic [L*R-1:0]   req_sel = '0;
    logic [L*W-1:0]   req_data = '0;
    logic             rf_stall = 1'b0;
    logic [L-1:0]     req_lock = '0;
    logic [L-1:0]     gnt;
    logic             wr_en;
    logic [R-1:0]     wr_sel;
    logic [W-1:0]     wr_data;
    logic             busy;

    typedef struct packed {
        logic [R-1:0] sel;
        logic [W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    regfile_wr_arbiter #(.S(S), .R(R), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_sel  (req_sel),
        .req_data (req_data),
        .rf_stall (rf_stall),
`ifdef ARB_LOCK_EN
        .req_lock (req_lock),
`endif
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Every write seen on the port must match the oldest expected transfer.
    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got sel=%0d data=%h, required no write", wr_sel, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (wr_sel !== mon_e.sel || wr_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL write_port: got sel=%0d data=%h, required sel=%0d data=%h",
                             wr_sel, wr_data, mon_e.sel, mon_e.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [R-1:0] s, input logic [W-1:0] d);
        req[i]            = 1'b1;
        req_sel[i*R +: R] = s;
        req_data[i*W +: W] = d;
    endtask

    task automatic test_reset();
        req = '1;
        #2;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL gnt_in_reset: got %b, required 0000", gnt); end
        n_cmp++; if ({wr_en, wr_sel, wr_data, busy} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got en=%b sel=%0d data=%h busy=%b, required all 0", wr_en, wr_sel, wr_data, busy);
        end
        req = '0;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cyc();
            n_cmp++; if (gnt !== 4'b0000 || wr_en !== 1'b0 || wr_sel !== 3'd0 || wr_data !== 16'h0 || busy !== 1'b0) begin
                n_err++; $display("FAIL idle[%0d]: got gnt=%b en=%b sel=%0d data=%h busy=%b, required all 0",
                                  n, gnt, wr_en, wr_sel, wr_data, busy);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [L-1:0] eg;
        for (int i = 0; i < L; i++) set_req(i, 3'(i + 1), 16'hC000 | 16'(i));
        for (int n = 0; n < 8; n++) begin
            eg = 4'b0001 << (n % 4);
            #1;
            n_cmp++; if (gnt !== eg) begin n_err++; $display("FAIL rr_gnt[%0d]: got %b, required %b", n, gnt, eg); end
            exp_q.push_back({3'((n % 4) + 1), 16'hC000 | 16'(n % 4)});
            cyc();
            n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL rr_wr_en[%0d]: got %b, required 1", n, wr_en); end
        end
        req = '0;
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rr_idle_gnt: got %b, required 0000", gnt); end
        cyc();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rr_idle_wr_en: got %b, required 0", wr_en); end
    endtask

    task automatic test_two_requesters();
        set_req(0, 3'd3, 16'hAAAA);
        set_req(2, 3'd5, 16'h5555);
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL two_gnt0: got %b, required 0001", gnt); end
        exp_q.push_back({3'd3, 16'hAAAA});
        cyc();
        req[0] = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL two_gnt2: got %b, required 0100", gnt); end
        exp_q.push_back({3'd5, 16'h5555});
        cyc();
        req[2] = 1'b0;
        cyc();
        n_cmp++; if (wr_en !== 1'b0 || wr_sel !== 3'd5 || wr_data !== 16'h5555) begin
            n_err++; $display("FAIL two_hold: got en=%b sel=%0d data=%h, required en=0 sel=5 data=5555", wr_en, wr_sel, wr_data);
        end
    endtask

    task automatic test_stall();
        rf_stall = 1'b1;
        set_req(1, 3'd6, 16'h1234);
        for (int n = 0; n < 3; n++) begin
            #1;
            n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL stall_gnt[%0d]: got %b, required 0000", n, gnt); end
            cyc();
            n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL stall_out[%0d]: got en=%b busy=%b, required en=0 busy=1", n, wr_en, busy);
            end
        end
        rf_stall = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL stall_release_gnt: got %b, required 0010", gnt); end
        exp_q.push_back({3'd6, 16'h1234});
        cyc();
        req[1] = 1'b0;
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL stall_release_wr_en: got %b, required 1", wr_en); end
        cyc();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL stall_pulse_end: got %b, required 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            set_req(0, 3'(n), 16'h0B00 | 16'(n));
            #1;
            n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b, required 0001", n, gnt); end
            exp_q.push_back({3'(n), 16'h0B00 | 16'(n)});
            cyc();
            n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL b2b_wr_en[%0d]: got %b, required 1", n, wr_en); end
        end
        // Stall while the last write is still on the port: it must not repeat.
        rf_stall = 1'b1;
        set_req(0, 3'd4, 16'h0B04);
        #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL b2b_stall_gnt: got %b, required 0000", gnt); end
        cyc();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL b2b_no_reissue: got %b, required 0", wr_en); end
        rf_stall = 1'b0;
        req = '0;
        cyc();
    endtask

    task automatic test_async_reset();
        set_req(2, 3'd2, 16'hBEEF);
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL ar_pre_gnt: got %b, required 0100", gnt); end
        exp_q.push_back({3'd2, 16'hBEEF});
        cyc();
        req = '0;
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL ar_pre_wr_en: got %b, required 1", wr_en); end
        #1;
        rst = 1'b1;
        set_req(0, 3'd1, 16'h1111);
        set_req(3, 3'd7, 16'h7777);
        #1;
        n_cmp++; if (wr_en !== 1'b0 || wr_sel !== 3'd0 || wr_data !== 16'h0 || gnt !== 4'b0000) begin
            n_err++; $display("FAIL ar_async_clear: got en=%b sel=%0d data=%h gnt=%b, required all 0", wr_en, wr_sel, wr_data, gnt);
        end
        exp_q.delete();
        cyc();
        rst = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL ar_restart_gnt: got %b, required 0001", gnt); end
        exp_q.push_back({3'd1, 16'h1111});
        cyc();
        req[0] = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL ar_second_gnt: got %b, required 1000", gnt); end
        exp_q.push_back({3'd7, 16'h7777});
        cyc();
        req[3] = 1'b0;
        cyc();
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        set_req(2, 3'd4, 16'h2222);
        #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL lk_pre_gnt: got %b, required 0100", gnt); end
        exp_q.push_back({3'd4, 16'h2222});
        cyc();
        req[2] = 1'b0;
        set_req(0, 3'd1, 16'h0A0A);
        set_req(3, 3'd7, 16'h3000);
        req_lock[3] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL lk_gnt[%0d]: got %b, required 1000", n, gnt); end
            exp_q.push_back({3'd7, 16'h3000 + 16'(n)});
            cyc();
            set_req(3, 3'd7, 16'h3000 + 16'(n + 1));
        end
        req_lock[3] = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b1000) begin n_err++; $display("FAIL lk_unlock_gnt: got %b, required 1000", gnt); end
        exp_q.push_back({3'd7, 16'h3003});
        cyc();
        req[3] = 1'b0;
        #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL lk_after_gnt: got %b, required 0001", gnt); end
        exp_q.push_back({3'd1, 16'h0A0A});
        cyc();
        req[0] = 1'b0;
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_two_requesters();
        test_stall();
        test_back_to_back();
        test_async_reset();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        cyc();
        cyc();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
